// File: rtl/cofi_auto_ctrl.sv
// rtl/cofi_auto_ctrl.sv - frame-level dither detector driving the cofi blend enable
// Counts horizontal dither hits per frame; a hysteresis FSM updates the enable only at vblank start.
module cofi_auto_ctrl #(
  parameter int CNT_W      = 20,
  parameter int THRESH_ON  = 4096,
  parameter int THRESH_OFF = 1024,
  parameter int FRAMES_ON  = 4,
  parameter int FRAMES_OFF = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             pix_ce,
  input  logic             hblank,
  input  logic             vblank,
  input  logic [7:0]       red,
  input  logic [7:0]       green,
  input  logic [7:0]       blue,
  input  logic [1:0]       mode,
  output logic             cofi_enable,
  output logic [1:0]       state,
  output logic [CNT_W-1:0] last_score
);

  typedef enum logic [1:0] {
    S_OFF     = 2'd0,
    S_ARM_ON  = 2'd1,
    S_ON      = 2'd2,
    S_ARM_OFF = 2'd3
  } state_t;

  // Frame counter is 4 bits wide, so limits above 15 clamp to 15.
  localparam logic [3:0]  FON_LIM  = (FRAMES_ON  > 15) ? 4'd15 : 4'(FRAMES_ON);
  localparam logic [3:0]  FOFF_LIM = (FRAMES_OFF > 15) ? 4'd15 : 4'(FRAMES_OFF);
  localparam logic [31:0] TON      = THRESH_ON;
  localparam logic [31:0] TOFF     = THRESH_OFF;

  state_t           st, nxt_st;
  logic [3:0]       frm, nxt_frm;
  logic [CNT_W-1:0] cnt;
  logic [23:0]      p1, p2;
  logic [1:0]       hist_vld;
  logic             vblank_d;
  logic [23:0]      pix;
  logic             active, hit, frame_end;
  logic [31:0]      score;

  assign pix       = {red, green, blue};
  assign active    = !hblank && !vblank;
  assign hit       = active && (hist_vld == 2'd2) && (pix == p2) && (pix != p1);
  assign frame_end = vblank && !vblank_d;
  assign score     = 32'(cnt);
  assign state     = st;

  always_comb begin
    nxt_st  = st;
    nxt_frm = frm;
    case (mode)
      2'd0: begin nxt_st = S_OFF; nxt_frm = 4'd0; end
      2'd1: begin nxt_st = S_ON;  nxt_frm = 4'd0; end
      default: begin
        case (st)
          S_OFF:
            if (score >= TON) begin
              if (FON_LIM == 4'd1) begin nxt_st = S_ON; nxt_frm = 4'd0; end
              else begin nxt_st = S_ARM_ON; nxt_frm = 4'd1; end
            end
          S_ARM_ON:
            if (score >= TON) begin
              if (frm + 4'd1 == FON_LIM) begin nxt_st = S_ON; nxt_frm = 4'd0; end
              else nxt_frm = frm + 4'd1;
            end else begin
              nxt_st = S_OFF; nxt_frm = 4'd0;
            end
          S_ON:
            if (score < TOFF) begin
              if (FOFF_LIM == 4'd1) begin nxt_st = S_OFF; nxt_frm = 4'd0; end
              else begin nxt_st = S_ARM_OFF; nxt_frm = 4'd1; end
            end
          default:
            if (score < TOFF) begin
              if (frm + 4'd1 == FOFF_LIM) begin nxt_st = S_OFF; nxt_frm = 4'd0; end
              else nxt_frm = frm + 4'd1;
            end else begin
              nxt_st = S_ON; nxt_frm = 4'd0;
            end
        endcase
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      st          <= S_OFF;
      frm         <= 4'd0;
      cnt         <= '0;
      last_score  <= '0;
      cofi_enable <= 1'b0;
      p1          <= 24'd0;
      p2          <= 24'd0;
      hist_vld    <= 2'd0;
      vblank_d    <= 1'b0;
    end else if (pix_ce) begin
      vblank_d <= vblank;
      if (!active) begin
        hist_vld <= 2'd0;
      end else begin
        p1 <= pix;
        p2 <= p1;
        if (hist_vld != 2'd2) hist_vld <= hist_vld + 2'd1;
      end
      // vblank is high on the frame-end sample, so it never coincides with a hit.
      if (frame_end) begin
        last_score  <= cnt;
        cnt         <= '0;
        st          <= nxt_st;
        frm         <= nxt_frm;
        cofi_enable <= (nxt_st == S_ON) || (nxt_st == S_ARM_OFF);
      end else if (hit && !(&cnt)) begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_cofi_auto_ctrl.sv
// tb/tb_cofi_auto_ctrl.sv - directed bench for cofi_auto_ctrl
// Small 10x4 frames (70x4 for saturation) with thresholds scaled to the frame size.
module tb_cofi_auto_ctrl;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        pix_ce;
  logic        hblank;
  logic        vblank;
  logic [7:0]  red, green, blue;
  logic [1:0]  mode;
  logic        en, en8;
  logic [1:0]  st, st8;
  logic [19:0] ls;
  logic [7:0]  ls8;

  int total = 0;
  int passed = 0;

  always #5 clk = ~clk;

  cofi_auto_ctrl #(.CNT_W(20), .THRESH_ON(24), .THRESH_OFF(8), .FRAMES_ON(4), .FRAMES_OFF(16)) dut (
    .clk(clk), .reset_n(reset_n), .pix_ce(pix_ce), .hblank(hblank), .vblank(vblank),
    .red(red), .green(green), .blue(blue), .mode(mode),
    .cofi_enable(en), .state(st), .last_score(ls)
  );

  cofi_auto_ctrl #(.CNT_W(8), .THRESH_ON(24), .THRESH_OFF(8), .FRAMES_ON(4), .FRAMES_OFF(16)) dut8 (
    .clk(clk), .reset_n(reset_n), .pix_ce(pix_ce), .hblank(hblank), .vblank(vblank),
    .red(red), .green(green), .blue(blue), .mode(mode),
    .cofi_enable(en8), .state(st8), .last_score(ls8)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
  endtask

  // kind: 0 solid grey, 1 dithered, 2 first two lines dithered, 3 wide dithered
  task automatic frame(input int kind, input logic [1:0] md, input bit pause);
    int  w;
    bit  chg;
    logic en0;
    logic [23:0] px;
    w   = (kind == 3) ? 70 : 10;
    chg = 1'b0;
    en0 = en;
    for (int l = 0; l < 4; l++) begin
      if (l == 2) mode = md;
      for (int x = 0; x < w; x++) begin
        @(negedge clk);
        if (en !== en0) chg = 1'b1;
        if (pause && l == 1 && x == 5) begin
          pix_ce = 1'b0; hblank = 1'b1; vblank = 1'b1;
          {red, green, blue} = 24'h123456;
          repeat (1000) @(negedge clk);
          pix_ce = 1'b1;
        end
        if (kind == 1 || kind == 3 || (kind == 2 && l < 2))
          px = x[0] ? 24'h0000FF : 24'hFF0000;
        else
          px = 24'h202020;
        {red, green, blue} = px;
        hblank = 1'b0; vblank = 1'b0;
      end
      @(negedge clk);
      if (en !== en0) chg = 1'b1;
      hblank = 1'b1;
      @(negedge clk);
    end
    @(negedge clk);
    vblank = 1'b1; hblank = 1'b1;
    repeat (3) @(negedge clk);
    chk("en_mid_frame_change", 32'(chg), 32'd0);
  endtask

  initial begin
    reset_n = 1'b0; pix_ce = 1'b1; hblank = 1'b1; vblank = 1'b0;
    red = 8'd0; green = 8'd0; blue = 8'd0; mode = 2'd2;
    repeat (2) @(negedge clk);
    chk("reset_en", 32'(en), 32'd0);
    chk("reset_state", 32'(st), 32'd0);
    chk("reset_score", 32'(ls), 32'd0);
    reset_n = 1'b1;

    // solid content never scores
    for (int i = 0; i < 5; i++) frame(0, 2'd2, 1'b0);
    chk("solid_score", 32'(ls), 32'd0);
    chk("solid_state", 32'(st), 32'd0);
    chk("solid_en", 32'(en), 32'd0);

    // dithered: 8 hits/line x 4 lines = 32
    frame(1, 2'd2, 1'b0);
    chk("dith1_score", 32'(ls), 32'd32);
    chk("dith1_state", 32'(st), 32'd1);
    chk("dith1_en", 32'(en), 32'd0);
    frame(1, 2'd2, 1'b0);
    frame(1, 2'd2, 1'b0);
    chk("dith3_state", 32'(st), 32'd1);
    chk("dith3_en", 32'(en), 32'd0);
    frame(1, 2'd2, 1'b0);
    chk("dith4_state", 32'(st), 32'd2);
    chk("dith4_en", 32'(en), 32'd1);

    // mid score (16) keeps ON
    frame(2, 2'd2, 1'b0);
    chk("mid_score", 32'(ls), 32'd16);
    chk("on_mid_state", 32'(st), 32'd2);

    // ARM_OFF, then mid score returns to ON and clears frame count
    for (int i = 0; i < 3; i++) frame(0, 2'd2, 1'b0);
    chk("armoff_state", 32'(st), 32'd3);
    chk("armoff_en", 32'(en), 32'd1);
    frame(2, 2'd2, 1'b0);
    chk("armoff_back_on", 32'(st), 32'd2);
    for (int i = 0; i < 14; i++) frame(0, 2'd2, 1'b0);
    chk("clean14_state", 32'(st), 32'd3);
    chk("clean14_en", 32'(en), 32'd1);
    frame(0, 2'd2, 1'b0);
    chk("clean15_state", 32'(st), 32'd0);
    chk("clean15_en", 32'(en), 32'd0);

    // dithered, dithered, solid drops ARM_ON back to OFF
    frame(1, 2'd2, 1'b0);
    frame(1, 2'd2, 1'b0);
    frame(0, 2'd2, 1'b0);
    chk("armon_drop_state", 32'(st), 32'd0);
    for (int i = 0; i < 3; i++) frame(1, 2'd2, 1'b0);
    chk("rearm3_en", 32'(en), 32'd0);
    frame(1, 2'd2, 1'b0);
    chk("rearm4_state", 32'(st), 32'd2);
    chk("rearm4_en", 32'(en), 32'd1);

    // forced modes applied mid-frame take effect at frame end only
    frame(1, 2'd0, 1'b0);
    chk("force_off_en", 32'(en), 32'd0);
    chk("force_off_state", 32'(st), 32'd0);
    frame(0, 2'd1, 1'b0);
    chk("force_on_en", 32'(en), 32'd1);
    chk("force_on_state", 32'(st), 32'd2);

    // pix_ce pause mid-line with garbage inputs
    frame(1, 2'd2, 1'b1);
    chk("pause_score", 32'(ls), 32'd32);
    chk("pause_state", 32'(st), 32'd2);

    // saturation: 68 hits/line x 4 = 272, clipped to 255 in the narrow build
    frame(0, 2'd0, 1'b0);
    frame(3, 2'd2, 1'b0);
    chk("wide_score", 32'(ls), 32'd272);
    chk("sat_score8", 32'(ls8), 32'd255);
    chk("sat_state8", 32'(st8), 32'd1);

    // asynchronous reset while armed
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    chk("areset_en8", 32'(en8), 32'd0);
    chk("areset_state8", 32'(st8), 32'd0);
    chk("areset_score8", 32'(ls8), 32'd0);
    chk("areset_score", 32'(ls), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
